// File: rtl/result_commit_pkg.sv
// Shared types for the result-commit stage: FSM states, the result bundle
// handed over by the ALU-result register, and a small address helper.
package result_commit_pkg;

  localparam int COMMIT_DATA_W = 32;
  localparam int COMMIT_REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    REG_WB   = 2'd2
  } commit_state_t;

  // Field order matches the ALU-result stage so the bundle can be passed as one vector.
  typedef struct packed {
    logic [COMMIT_DATA_W-1:0] data;
    logic [COMMIT_DATA_W-1:0] mem_addr;
    logic [COMMIT_REG_W-1:0]  reg_num;
    logic                     reg_en;
    logic                     mem_en;
  } result_bundle_t;

  // Stores are word-sized; any nonzero low address bit makes them unservable.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/result_commit_if.sv
// Store bus between the commit stage (master) and data memory (slave).
// The request is held with stable address/data until ack or abort.
interface result_commit_if #(
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/result_commit_timeout_ctr.sv
// Store-timeout down-counter. Loaded when a store is launched, decremented
// each cycle the store waits; expired marks the last cycle the request may
// still be held before the store is abandoned.
module result_commit_timeout_ctr #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  // Loading MEM_TIMEOUT-1 makes expiry coincide with the MEM_TIMEOUT-th waiting edge.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Load on store launch, count down while waiting, hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/result_commit.sv
// Retires the latched ALU-result bundle: issues word stores over the memory
// handshake, writes the register file, flags misaligned/aborted stores and
// overruns, and counts retired bundles. commit_busy stalls the upstream stage.
module result_commit
  import result_commit_pkg::*;
#(
  parameter int DATA_W      = COMMIT_DATA_W,
  parameter int REG_W       = COMMIT_REG_W,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid_in,
  input  logic [DATA_W-1:0] commit_data_in,
  input  logic [DATA_W-1:0] commit_mem_addr_in,
  input  logic [REG_W-1:0]  commit_reg_num_in,
  input  logic              commit_reg_enable_in,
  input  logic              commit_mem_enable_in,
  result_commit_if.master   mem_bus,
  output logic              commit_busy,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              err_align,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic [31:0]       retired_count
);

  commit_state_t  state;
  result_bundle_t bundle_in;
  result_bundle_t bundle_p1;
  logic           launch_store;
  logic           tmo_load;
  logic           tmo_dec;
  logic           tmo_expired;
  logic           unused_mem_en;

  // Register 0 is hard-wired, so writes to it are swallowed (the retire still counts).
  function automatic logic rf_write_ok(input logic en, input logic [REG_W-1:0] num);
    return en && (num != '0);
  endfunction

  // Assemble the incoming bundle and decide whether this strobe launches a store.
  always_comb begin
    bundle_in          = '0;
    bundle_in.data     = commit_data_in;
    bundle_in.mem_addr = commit_mem_addr_in;
    bundle_in.reg_num  = commit_reg_num_in;
    bundle_in.reg_en   = commit_reg_enable_in;
    bundle_in.mem_en   = commit_mem_enable_in;
    launch_store       = (state == IDLE) && commit_valid_in && commit_mem_enable_in &&
                         !addr_misaligned(commit_mem_addr_in[1:0]);
    tmo_load           = launch_store;
    tmo_dec            = (state == MEM_WAIT);
  end

  result_commit_timeout_ctr #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .dec     (tmo_dec),
    .expired (tmo_expired)
  );

  // Store address/data come straight from the latched bundle, which cannot
  // change while a store is outstanding because new strobes are refused.
  assign mem_bus.mem_addr  = bundle_p1.mem_addr;
  assign mem_bus.mem_wdata = bundle_p1.data;

  // The store-enable bit has already been acted on by the time it is latched.
  assign unused_mem_en = bundle_p1.mem_en;

  // Commit FSM: latch, dispatch, wait for the store, write back, count retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bundle_p1       <= '0;
      commit_busy     <= 1'b0;
      mem_bus.mem_req <= 1'b0;
      rf_we           <= 1'b0;
      rf_waddr        <= '0;
      rf_wdata        <= '0;
      err_align       <= 1'b0;
      err_timeout     <= 1'b0;
      err_overrun     <= 1'b0;
      retired_count   <= '0;
    end else begin
      rf_we       <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= commit_valid_in && (state != IDLE);

      case (state)
        IDLE: begin
          if (commit_valid_in) begin
            bundle_p1 <= bundle_in;
            if (bundle_in.mem_en) begin
              if (addr_misaligned(bundle_in.mem_addr[1:0])) begin
                err_align <= 1'b1;
                if (bundle_in.reg_en) begin
                  state       <= REG_WB;
                  commit_busy <= 1'b1;
                end else begin
                  retired_count <= retired_count + 32'd1;
                end
              end else begin
                mem_bus.mem_req <= 1'b1;
                state           <= MEM_WAIT;
                commit_busy     <= 1'b1;
              end
            end else if (bundle_in.reg_en) begin
              rf_we         <= rf_write_ok(1'b1, bundle_in.reg_num);
              rf_waddr      <= bundle_in.reg_num;
              rf_wdata      <= bundle_in.data;
              retired_count <= retired_count + 32'd1;
            end
          end
        end

        MEM_WAIT: begin
          // Ack on the expiry edge still counts as a successful store.
          if (mem_bus.mem_ack || tmo_expired) begin
            mem_bus.mem_req <= 1'b0;
            err_timeout     <= !mem_bus.mem_ack;
            rf_we           <= rf_write_ok(bundle_p1.reg_en, bundle_p1.reg_num);
            rf_waddr        <= bundle_p1.reg_num;
            rf_wdata        <= bundle_p1.data;
            retired_count   <= retired_count + 32'd1;
            state           <= IDLE;
            commit_busy     <= 1'b0;
          end
        end

        REG_WB: begin
          rf_we         <= rf_write_ok(bundle_p1.reg_en, bundle_p1.reg_num);
          rf_waddr      <= bundle_p1.reg_num;
          rf_wdata      <= bundle_p1.data;
          retired_count <= retired_count + 32'd1;
          state         <= IDLE;
          commit_busy   <= 1'b0;
        end

        default: begin
          mem_bus.mem_req <= 1'b0;
          state           <= IDLE;
          commit_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
